div_reservation_station: RTL
============================

// Module: div_reservation_station
// PURPOSE
//  Reservation station feeding the divide issue/execute stage. Holds up to ENTRIES dispatched divide ops.
//  Each entry snoops the CDB for missing operands.
//  Presents the oldest fully-ready entry to the divider stage and retires it on a valid/stall handshake.
//  Sits between dispatch/rename (upstream) and issueExecStageDiv (downstream).
// PARAMETERS
//  ROBsize     8                    ROB entries; sets tag width
//  ROBsizeLog  $clog2(ROBsize+1)    tag width (4 at default)
//  ENTRIES     4                    station depth, >=2
// PORTS
//  clk_i                         in   1    clock, rising edge
//  reset_i                       in   1    synchronous, active-high reset
//  flush_i                       in   1    drop all entries (mispredict), sync
//  dispatchValid_i               in   1    dispatch request this cycle
//  dispatchVal1_i/Val2_i         in   64   operand values (dividend/divisor)
//  dispatchRdy1_i/Rdy2_i         in   1    operand value already valid
//  dispatchSrc1_i/Src2_i         in   ROBsizeLog  producer ROB tag when not ready
//  dispatchCommands_i            in   10   opcode/control bits, passed through
//  dispatchTag_i                 in   ROBsizeLog  destination ROB tag
//  full_o                        out  1    no free entry; dispatch ignored
//  cdbValid_i                    in   1    CDB broadcast valid
//  cdbTag_i                      in   ROBsizeLog  broadcasting ROB tag
//  cdbVal_i                      in   64   broadcast result
//  reservationStationVal1_o/Val2_o  out 64 issuing entry operands
//  reservationStationCommands_o  out  10   issuing entry commands
//  reservationStationTag_o       out  ROBsizeLog  issuing entry dest tag
//  readyRS_o                     out  1    an entry has both operands ready
//  stallRS_i                     in   1    downstream refuses; issue fires iff readyRS_o & ~stallRS_i
// BEHAVIOUR
//  - Storage: age-ordered compacting queue. Slot 0 is oldest. count_r holds 0..ENTRIES.
//  - Reset or flush (at the edge): count_r=0 and all valid bits=0.
//    All outputs then read 0: readyRS_o=0, full_o=0, data/tag/commands=0.
//  - full_o = (count_r==ENTRIES), registered-state based. No same-cycle refill of a full station, even while issuing.
//  - Dispatch when dispatchValid_i & ~full_o: entry written at slot count_r (after compaction if issuing same cycle).
//  - Dispatch + CDB bypass: if ~dispatchRdyN_i, cdbValid_i and cdbTag_i==dispatchSrcN_i in the same cycle,
//    the entry stores cdbVal_i with ready=1.
//  - Snoop: each valid entry with a not-ready operand whose src tag matches a valid CDB captures cdbVal_i and sets ready at the edge.
//    Both operands may match the same broadcast.
//  - Select: readyRS_o=1 iff some valid entry has rdy1&rdy2 (registered flags only; no CDB-to-issue combinational path).
//    The lowest-index such entry drives the *_o data. Outputs are 0 when readyRS_o=0.
//  - Issue: on readyRS_o & ~stallRS_i at the edge, the selected entry is removed and younger slots shift down one. count_r decrements.
//  - Issue + dispatch same cycle: count_r unchanged; the new entry lands at slot count_r-1.
//  - stallRS_i high: nothing removed; selection may change next cycle if an older entry became ready.
//  - Latency: dispatch with ready operands -> readyRS_o next cycle. CDB wake-up -> readyRS_o next cycle.
//  - stallRS_i is combinational from readyRS_o downstream. No combinational path from stallRS_i back to readyRS_o.
//  - flush_i wins over dispatch/issue/snoop in the same cycle. reset_i wins over flush_i.
//  - Dispatch while full: silently dropped, no state change. Upstream must honour full_o.
// STRUCTURE
//  - Package div_rs_pkg: DATA_W=64, CMD_W=10, rs_entry_t struct
//    {valid, rdy1, rdy2, src1, src2, val1, val2, commands, tag}, and a tag-width function of ROBsize.
//  - Sub-module div_rs_slot: one entry register with snoop/capture logic.
//    Next-state mux: hold / shift-in from slot+1 / dispatch-write / clear. Instantiated ENTRIES times by generate.
//  - Top: count register, priority select (lowest-index ready), compaction control, output mux.
// TESTING
//  1 Reset: assert reset_i 2 cycles with dispatchValid_i=1 -> count 0, full_o=0, readyRS_o=0, all data outputs 0.
//  2 Ready dispatch: Val1=15, Val2=3, both rdy, cmd=10, tag=3, stallRS_i=0 -> next cycle readyRS_o=1 with 15/3/10/3.
//    Entry is gone the cycle after issue.
//  3 Wake-up: dispatch Val1=100 rdy, src2=5 not rdy -> readyRS_o stays 0.
//    CDB tag=5, val=7 -> next cycle readyRS_o=1, Val2_o=7.
//  4 Bypass: dispatch src1=2 not rdy while CDB tag=2, val=42 in the same cycle -> entry stored with Val1=42, rdy.
//  5 Full/order: dispatch 4 ready ops (tags 1..4) under stallRS_i=1 -> full_o=1 and a 5th dispatch is dropped.
//    Release stall -> issue order 1,2,3,4 on consecutive cycles.
//  6 Out-of-order ready + flush: oldest waits on tag 6, younger ready -> younger (tag 2) issues first.
//    Then flush_i with issue pending -> count 0 and readyRS_o=0 next cycle.

Source files
------------

// File: rtl/div_rs_pkg.sv
// Shared types and constants for the divide reservation station.
// Tag fields are stored at TAG_MAX bits and zero-extended from the ROB tag width.
package div_rs_pkg;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned CMD_W   = 10;
  localparam int unsigned TAG_MAX = 8;

  typedef struct packed {
    logic               valid;
    logic               rdy1;
    logic               rdy2;
    logic [TAG_MAX-1:0] src1;
    logic [TAG_MAX-1:0] src2;
    logic [DATA_W-1:0]  val1;
    logic [DATA_W-1:0]  val2;
    logic [CMD_W-1:0]   commands;
    logic [TAG_MAX-1:0] tag;
  } rs_entry_t;

  function automatic int unsigned tag_width(input int unsigned rob_size);
    return $clog2(rob_size + 1);
  endfunction

endpackage

// File: rtl/div_rs_slot.sv
// One reservation-station entry: hold / shift-in / dispatch-write / clear,
// followed by CDB snoop on whichever entry is about to be stored.
module div_rs_slot
  import div_rs_pkg::*;
(
  input  logic               clk_i,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic               write_i,
  input  rs_entry_t          upper_i,
  input  rs_entry_t          wr_i,
  input  logic               cdb_valid_i,
  input  logic [TAG_MAX-1:0] cdb_tag_i,
  input  logic [DATA_W-1:0]  cdb_val_i,
  output rs_entry_t          entry_o
);

  rs_entry_t nxt;

  // Snooping after the source mux also covers the dispatch-time CDB bypass.
  always_comb begin
    nxt = entry_o;
    if (write_i)      nxt = wr_i;
    else if (shift_i) nxt = upper_i;
    if (nxt.valid && cdb_valid_i) begin
      if (!nxt.rdy1 && nxt.src1 == cdb_tag_i) begin
        nxt.rdy1 = 1'b1;
        nxt.val1 = cdb_val_i;
      end
      if (!nxt.rdy2 && nxt.src2 == cdb_tag_i) begin
        nxt.rdy2 = 1'b1;
        nxt.val2 = cdb_val_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) entry_o <= '0;
    else         entry_o <= nxt;
  end

endmodule

// File: rtl/div_reservation_station.sv
// Age-ordered compacting reservation station for the divide unit; issues the
// oldest entry whose operands are both ready. ROBsizeLog must not exceed TAG_MAX.
module div_reservation_station
  import div_rs_pkg::*;
#(
  parameter int unsigned ROBsize    = 8,
  parameter int unsigned ROBsizeLog = tag_width(ROBsize),
  parameter int unsigned ENTRIES    = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  dispatchValid_i,
  input  logic [DATA_W-1:0]     dispatchVal1_i,
  input  logic [DATA_W-1:0]     dispatchVal2_i,
  input  logic                  dispatchRdy1_i,
  input  logic                  dispatchRdy2_i,
  input  logic [ROBsizeLog-1:0] dispatchSrc1_i,
  input  logic [ROBsizeLog-1:0] dispatchSrc2_i,
  input  logic [CMD_W-1:0]      dispatchCommands_i,
  input  logic [ROBsizeLog-1:0] dispatchTag_i,
  output logic                  full_o,
  input  logic                  cdbValid_i,
  input  logic [ROBsizeLog-1:0] cdbTag_i,
  input  logic [DATA_W-1:0]     cdbVal_i,
  output logic [DATA_W-1:0]     reservationStationVal1_o,
  output logic [DATA_W-1:0]     reservationStationVal2_o,
  output logic [CMD_W-1:0]      reservationStationCommands_o,
  output logic [ROBsizeLog-1:0] reservationStationTag_o,
  output logic                  readyRS_o,
  input  logic                  stallRS_i
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned CNT_W = $clog2(ENTRIES + 1);

  logic [CNT_W-1:0]   count_r, count_nxt, wr_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               ready, issue, accept, clear;
  logic [TAG_MAX-1:0] cdb_tag;
  rs_entry_t          slot_q [ENTRIES];
  rs_entry_t          wr_entry, sel_e;

  assign clear   = reset_i | flush_i;
  assign cdb_tag = TAG_MAX'(cdbTag_i);
  assign full_o  = (count_r == CNT_W'(ENTRIES));
  assign accept  = dispatchValid_i & ~full_o;
  assign issue   = ready & ~stallRS_i;
  assign wr_idx  = issue ? count_r - CNT_W'(1) : count_r;

  always_comb begin
    ready   = 1'b0;
    sel_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!ready && slot_q[i].valid && slot_q[i].rdy1 && slot_q[i].rdy2) begin
        ready   = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign sel_e                        = slot_q[sel_idx];
  assign readyRS_o                    = ready;
  assign reservationStationVal1_o     = ready ? sel_e.val1 : '0;
  assign reservationStationVal2_o     = ready ? sel_e.val2 : '0;
  assign reservationStationCommands_o = ready ? sel_e.commands : '0;
  assign reservationStationTag_o      = ready ? sel_e.tag[ROBsizeLog-1:0] : '0;

  always_comb begin
    wr_entry          = '0;
    wr_entry.valid    = 1'b1;
    wr_entry.rdy1     = dispatchRdy1_i;
    wr_entry.rdy2     = dispatchRdy2_i;
    wr_entry.src1     = TAG_MAX'(dispatchSrc1_i);
    wr_entry.src2     = TAG_MAX'(dispatchSrc2_i);
    wr_entry.val1     = dispatchVal1_i;
    wr_entry.val2     = dispatchVal2_i;
    wr_entry.commands = dispatchCommands_i;
    wr_entry.tag      = TAG_MAX'(dispatchTag_i);
  end

  always_comb begin
    count_nxt = count_r;
    case ({accept, issue})
      2'b10:   count_nxt = count_r + CNT_W'(1);
      2'b01:   count_nxt = count_r - CNT_W'(1);
      default: count_nxt = count_r;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear) count_r <= '0;
    else       count_r <= count_nxt;
  end

  // Slots at or above the issuing index take their younger neighbour; the top slot takes an empty entry.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_slot
    rs_entry_t upper;
    if (g == ENTRIES - 1) begin : g_top
      assign upper = '0;
    end else begin : g_mid
      assign upper = slot_q[g+1];
    end

    div_rs_slot u_slot (
      .clk_i       (clk_i),
      .clear_i     (clear),
      .shift_i     (issue && (IDX_W'(g) >= sel_idx)),
      .write_i     (accept && (wr_idx == CNT_W'(g))),
      .upper_i     (upper),
      .wr_i        (wr_entry),
      .cdb_valid_i (cdbValid_i),
      .cdb_tag_i   (cdb_tag),
      .cdb_val_i   (cdbVal_i),
      .entry_o     (slot_q[g])
    );
  end

endmodule
